// File: rtl/data_structs.sv
`default_nettype none
// ============================================================
// Package  : data_structs
// Brief    : Shared datapath types plus fixed-point saturate/multiply helpers.
// Revision : 1.0
// ============================================================
package data_structs;

    localparam int RT_FRAC_DEFAULT = 12;
    localparam int RT_WIDE_W       = 128;

    typedef logic signed [RT_WIDE_W-1:0] rt_wide_t;

    typedef logic signed [23:0] fx24_t;
    typedef struct packed { fx24_t z; fx24_t y; fx24_t x; } vec3;
    typedef struct packed { fx24_t y; fx24_t x; } vec2;
    typedef struct packed { vec3 bmax; vec3 bmin; } bbox;

    // Clamp a wide signed value into the signed w-bit range; caller narrows.
    function automatic rt_wide_t sat_w(input rt_wide_t v, input int w);
        rt_wide_t lim_hi;
        rt_wide_t lim_lo;
        lim_hi = (rt_wide_t'(1) <<< (w - 1)) - rt_wide_t'(1);
        lim_lo = -(rt_wide_t'(1) <<< (w - 1));
        if (v > lim_hi) return lim_hi;
        if (v < lim_lo) return lim_lo;
        return v;
    endfunction

    // Operands are sign-extended W-bit words, so the product never overflows.
    function automatic rt_wide_t fx_mul(input rt_wide_t a, input rt_wide_t b,
                                        input int w, input int frac);
        rt_wide_t prod;
        prod = (a * b) >>> frac;
        return sat_w(prod, w);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rbi_axis_slab.sv
`default_nettype none
// ============================================================
// Module   : rbi_axis_slab
// Brief    : Single-axis slab stages S1-S3: difference, scale, swap and clip.
// Revision : 1.0
// ============================================================
module rbi_axis_slab
    import data_structs::*;
#(
    parameter int W    = 24,
    parameter int FRAC = RT_FRAC_DEFAULT
) (
    input  logic                sysclk,
    input  logic                en,
    input  logic signed [W-1:0] orig,
    input  logic signed [W-1:0] inv_dir,
    input  logic signed [W-1:0] box_lo,
    input  logic signed [W-1:0] box_hi,
    input  logic signed [W-1:0] range_tmin,
    input  logic signed [W-1:0] range_tmax,
    output logic signed [W-1:0] tmin_a,
    output logic signed [W-1:0] tmax_a
);

    logic signed [W:0]   w_d0_wide;
    logic signed [W:0]   w_d1_wide;
    logic signed [W-1:0] w_d0;
    logic signed [W-1:0] w_d1;
    logic signed [W-1:0] w_t0;
    logic signed [W-1:0] w_t1;
    logic signed [W-1:0] w_lo;
    logic signed [W-1:0] w_hi;

    logic signed [W-1:0] r_d0;
    logic signed [W-1:0] r_d1;
    logic signed [W-1:0] r_inv;
    logic signed [W-1:0] r_t0;
    logic signed [W-1:0] r_t1;
    logic                r_neg;
    logic signed [W-1:0] r_tmin;
    logic signed [W-1:0] r_tmax;

    assign w_d0_wide = $signed({box_lo[W-1], box_lo}) - $signed({orig[W-1], orig});
    assign w_d1_wide = $signed({box_hi[W-1], box_hi}) - $signed({orig[W-1], orig});
    assign w_d0      = W'(sat_w(rt_wide_t'(w_d0_wide), W));
    assign w_d1      = W'(sat_w(rt_wide_t'(w_d1_wide), W));

    assign w_t0 = W'(fx_mul(rt_wide_t'(r_d0), rt_wide_t'(r_inv), W, FRAC));
    assign w_t1 = W'(fx_mul(rt_wide_t'(r_d1), rt_wide_t'(r_inv), W, FRAC));

    // A negative reciprocal means the far plane is hit first on this axis.
    assign w_lo = r_neg ? r_t1 : r_t0;
    assign w_hi = r_neg ? r_t0 : r_t1;

    always_ff @(posedge sysclk) begin
        if (en) begin
            r_d0   <= w_d0;
            r_d1   <= w_d1;
            r_inv  <= inv_dir;
            r_t0   <= w_t0;
            r_t1   <= w_t1;
            r_neg  <= r_inv[W-1];
            r_tmin <= (w_lo > range_tmin) ? w_lo : range_tmin;
            r_tmax <= (w_hi < range_tmax) ? w_hi : range_tmax;
        end
    end

    assign tmin_a = r_tmin;
    assign tmax_a = r_tmax;

endmodule
`default_nettype wire

// File: rtl/ray_bbox_intersect_pipe.sv
`default_nettype none
// ============================================================
// Module   : ray_bbox_intersect_pipe
// Brief    : 4-stage ray/AABB slab test with tag pass-through and hit statistics.
// Revision : 1.0
// ============================================================
module ray_bbox_intersect_pipe
    import data_structs::*;
#(
    parameter int W     = 24,
    parameter int FRAC  = RT_FRAC_DEFAULT,
    parameter int TAG_W = 8,
    parameter int CNT_W = 32
) (
    input  logic               sysclk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3*W-1:0]     in_ray_orig,
    input  logic [3*W-1:0]     in_inv_dir,
    input  logic [3*W-1:0]     in_box_min,
    input  logic [3*W-1:0]     in_box_max,
    input  logic [2*W-1:0]     in_range,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_hit,
    output logic [2*W-1:0]     out_range,
    output logic [TAG_W-1:0]   out_tag,
    input  logic               stat_clear,
    output logic [CNT_W-1:0]   stat_rays,
    output logic [CNT_W-1:0]   stat_hits
);

    logic                w_en;
    logic                r_v1, r_v2, r_v3, r_v4;
    logic [2*W-1:0]      r_rng1, r_rng2;
    logic [TAG_W-1:0]    r_tag1, r_tag2, r_tag3;
    logic signed [W-1:0] w_tmin_a [3];
    logic signed [W-1:0] w_tmax_a [3];
    logic signed [W-1:0] w_tmin;
    logic signed [W-1:0] w_tmax;
    logic                r_hit;
    logic [2*W-1:0]      r_out_rng;
    logic [TAG_W-1:0]    r_out_tag;
    logic [CNT_W-1:0]    r_stat_rays;
    logic [CNT_W-1:0]    r_stat_hits;

    // Whole pipeline moves as one; only a held output can stop it.
    assign w_en     = ~r_v4 | out_ready;
    assign in_ready = w_en;

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
            r_v4 <= 1'b0;
        end else if (w_en) begin
            r_v1 <= in_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
            r_v4 <= r_v3;
        end
    end

    always_ff @(posedge sysclk) begin
        if (w_en) begin
            r_rng1 <= in_range;
            r_rng2 <= r_rng1;
            r_tag1 <= in_tag;
            r_tag2 <= r_tag1;
            r_tag3 <= r_tag2;
        end
    end

    generate
        for (genvar a = 0; a < 3; a++) begin : g_axis
            rbi_axis_slab #(
                .W    (W),
                .FRAC (FRAC)
            ) u_slab (
                .sysclk     (sysclk),
                .en         (w_en),
                .orig       (in_ray_orig[a*W +: W]),
                .inv_dir    (in_inv_dir[a*W +: W]),
                .box_lo     (in_box_min[a*W +: W]),
                .box_hi     (in_box_max[a*W +: W]),
                .range_tmin (r_rng2[W-1:0]),
                .range_tmax (r_rng2[2*W-1:W]),
                .tmin_a     (w_tmin_a[a]),
                .tmax_a     (w_tmax_a[a])
            );
        end
    endgenerate

    always_comb begin
        w_tmin = w_tmin_a[0];
        w_tmax = w_tmax_a[0];
        for (int a = 1; a < 3; a++) begin
            if (w_tmin_a[a] > w_tmin) w_tmin = w_tmin_a[a];
            if (w_tmax_a[a] < w_tmax) w_tmax = w_tmax_a[a];
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_hit     <= 1'b0;
            r_out_rng <= '0;
            r_out_tag <= '0;
        end else if (w_en) begin
            r_hit     <= (w_tmax > w_tmin);
            r_out_rng <= {w_tmax, w_tmin};
            r_out_tag <= r_tag3;
        end
    end

    always_ff @(posedge sysclk or posedge rst) begin
        if (rst) begin
            r_stat_rays <= '0;
            r_stat_hits <= '0;
        end else if (stat_clear) begin
            r_stat_rays <= '0;
            r_stat_hits <= '0;
        end else if (r_v4 && out_ready) begin
            if (r_stat_rays != '1) r_stat_rays <= r_stat_rays + CNT_W'(1);
            if (r_hit && (r_stat_hits != '1)) r_stat_hits <= r_stat_hits + CNT_W'(1);
        end
    end

    assign out_valid = r_v4;
    assign out_hit   = r_hit;
    assign out_range = r_out_rng;
    assign out_tag   = r_out_tag;
    assign stat_rays = r_stat_rays;
    assign stat_hits = r_stat_hits;

endmodule
`default_nettype wire

// File: tb/tb_ray_bbox_intersect_pipe.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================
// Module   : tb_ray_bbox_intersect_pipe
// Brief    : Directed scoreboard bench for ray_bbox_intersect_pipe.
// Revision : 1.0
// ============================================================
module tb_ray_bbox_intersect_pipe;

    localparam int     W     = 24;
    localparam int     FRAC  = 12;
    localparam int     TAG_W = 8;
    localparam int     CNT_W = 32;
    localparam longint ONE   = 4096;

    logic               sysclk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [3*W-1:0]     in_ray_orig;
    logic [3*W-1:0]     in_inv_dir;
    logic [3*W-1:0]     in_box_min;
    logic [3*W-1:0]     in_box_max;
    logic [2*W-1:0]     in_range;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic               out_hit;
    logic [2*W-1:0]     out_range;
    logic [TAG_W-1:0]   out_tag;
    logic               stat_clear;
    logic [CNT_W-1:0]   stat_rays;
    logic [CNT_W-1:0]   stat_hits;

    typedef struct {
        logic             hit;
        logic [2*W-1:0]   rng;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_hits = 0;

    logic             stall_prev = 1'b0;
    logic             held_hit;
    logic [2*W-1:0]   held_rng;
    logic [TAG_W-1:0] held_tag;

    always #5 sysclk = ~sysclk;

    ray_bbox_intersect_pipe #(
        .W(W), .FRAC(FRAC), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .sysclk      (sysclk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_ray_orig (in_ray_orig),
        .in_inv_dir  (in_inv_dir),
        .in_box_min  (in_box_min),
        .in_box_max  (in_box_max),
        .in_range    (in_range),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_hit     (out_hit),
        .out_range   (out_range),
        .out_tag     (out_tag),
        .stat_clear  (stat_clear),
        .stat_rays   (stat_rays),
        .stat_hits   (stat_hits)
    );

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", nm, obs, expv);
        end
    endtask

    function automatic logic [3*W-1:0] v3(input longint x, input longint y, input longint z);
        return {z[23:0], y[23:0], x[23:0]};
    endfunction

    function automatic logic [2*W-1:0] rg(input longint tmin, input longint tmax);
        return {tmax[23:0], tmin[23:0]};
    endfunction

    function automatic longint sx(input logic [23:0] v);
        longint s;
        s = $signed(v);
        return s;
    endfunction

    function automatic longint sat(input longint v);
        if (v > longint'(8388607)) return longint'(8388607);
        if (v < -longint'(8388608)) return -longint'(8388608);
        return v;
    endfunction

    // Reference slab test: overall range is the prior range narrowed by every axis.
    function automatic exp_t model(input logic [3*W-1:0] o, input logic [3*W-1:0] iv,
                                   input logic [3*W-1:0] lo, input logic [3*W-1:0] hi,
                                   input logic [2*W-1:0] r, input logic [TAG_W-1:0] tg);
        exp_t   e;
        longint mn, mx, oa, ia, t0, t1, tt;
        mn = sx(r[23:0]);
        mx = sx(r[47:24]);
        for (int a = 0; a < 3; a++) begin
            oa = sx(o[a*24 +: 24]);
            ia = sx(iv[a*24 +: 24]);
            t0 = sat((sat(sx(lo[a*24 +: 24]) - oa) * ia) >>> FRAC);
            t1 = sat((sat(sx(hi[a*24 +: 24]) - oa) * ia) >>> FRAC);
            if (ia < 0) begin
                tt = t0; t0 = t1; t1 = tt;
            end
            if (t0 > mn) mn = t0;
            if (t1 < mx) mx = t1;
        end
        e.hit = (mx > mn);
        e.rng = {mx[23:0], mn[23:0]};
        e.tag = tg;
        return e;
    endfunction

    task automatic send(input logic [3*W-1:0] o, input logic [3*W-1:0] iv,
                        input logic [3*W-1:0] lo, input logic [3*W-1:0] hi,
                        input logic [2*W-1:0] r, input logic [TAG_W-1:0] tg);
        logic ok;
        int   n;
        in_ray_orig = o;
        in_inv_dir  = iv;
        in_box_min  = lo;
        in_box_max  = hi;
        in_range    = r;
        in_tag      = tg;
        in_valid    = 1'b1;
        n = 0;
        do begin
            @(negedge sysclk);
            ok = in_ready;
            @(posedge sysclk);
            #1;
            n++;
        end while (!ok && n < 100);
        if (ok) sb.push_back(model(o, iv, lo, hi, r, tg));
        else chk("send_timeout_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(negedge sysclk);
            n++;
        end
        chk({nm, "_drain_left"}, 64'(sb.size()), 64'd0);
        @(posedge sysclk);
        #1;
    endtask

    // Output side: stall stability, backpressure on input, in-order scoreboard.
    always @(negedge sysclk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
                chk("stall_out_hit",   {63'd0, out_hit},   {63'd0, held_hit});
                chk("stall_out_range", 64'(out_range),     64'(held_rng));
                chk("stall_out_tag",   64'(out_tag),       64'(held_tag));
            end
            if (out_valid && !out_ready) begin
                chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
                held_hit   = out_hit;
                held_rng   = out_range;
                held_tag   = out_tag;
                stall_prev = 1'b1;
            end else begin
                stall_prev = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", {63'd0, out_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_tag",   64'(out_tag),      64'(e.tag));
                    chk("sb_hit",   {63'd0, out_hit},  {63'd0, e.hit});
                    chk("sb_range", 64'(out_range),    64'(e.rng));
                    if (e.hit) exp_hits = exp_hits + 1;
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        stat_clear  = 1'b0;
        in_ray_orig = '0;
        in_inv_dir  = '0;
        in_box_min  = '0;
        in_box_max  = '0;
        in_range    = '0;
        in_tag      = '0;

        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_out_hit",   {63'd0, out_hit},   64'd0);
        chk("rst_out_range", 64'(out_range),     64'd0);
        chk("rst_out_tag",   64'(out_tag),       64'd0);
        chk("rst_stat_rays", 64'(stat_rays),     64'd0);
        chk("rst_stat_hits", 64'(stat_hits),     64'd0);
        rst = 1'b0;
        @(negedge sysclk);
        chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);
        @(posedge sysclk);
        #1;

        // Basic hit, with exact 4-cycle latency
        send(v3(0, 0, 0), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), v3(2*ONE, 2*ONE, 2*ONE),
             rg(0, 100*ONE), 8'h11);
        repeat (2) @(posedge sysclk);
        #1;
        chk("latency_not_early", {63'd0, out_valid}, 64'd0);
        @(posedge sysclk);
        #1;
        chk("latency_on_time", {63'd0, out_valid}, 64'd1);
        chk("basic_range", 64'(out_range), 64'h001000_001000 + 64'h001000_000000);
        drain("basic");

        // Negative direction, miss, tie, saturation back to back
        send(v3(0, 0, 0), v3(-ONE, ONE, ONE), v3(-2*ONE, ONE, ONE), v3(-ONE, 2*ONE, 2*ONE),
             rg(0, 100*ONE), 8'h22);
        send(v3(0, 0, 0), v3(ONE, ONE, ONE), v3(3*ONE, 0, 0), v3(4*ONE, ONE, ONE),
             rg(0, 100*ONE), 8'h33);
        send(v3(0, 0, 0), v3(ONE, ONE, ONE), v3(ONE, 2*ONE, ONE), v3(2*ONE, 3*ONE, 2*ONE),
             rg(0, 100*ONE), 8'h44);
        send(v3(-64'sh7FF000, 0, 0), v3(4*ONE, ONE, ONE), v3(-64'sh7FF000 + ONE, -ONE, -ONE),
             v3(64'sh7FF000, 64'sh7FFFFF, 64'sh7FFFFF), rg(0, 64'sh7FFFFF), 8'h55);
        drain("directed");
        chk("directed_stat_rays", 64'(stat_rays), 64'd5);
        chk("directed_stat_hits", 64'(stat_hits), 64'd3);
        chk("directed_hits_model", 64'(stat_hits), 64'(exp_hits));

        stat_clear = 1'b1;
        @(posedge sysclk);
        #1;
        stat_clear = 1'b0;
        exp_hits   = 0;
        chk("clear_stat_rays", 64'(stat_rays), 64'd0);
        chk("clear_stat_hits", 64'(stat_hits), 64'd0);

        // Backpressure: 8 back-to-back requests, output stalled for 4 cycles
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(v3(0, 0, 0), v3(ONE, ONE, ONE), v3(i*ONE, 2*ONE, 0),
                         v3((i+3)*ONE, 3*ONE, 10*ONE), rg(0, 100*ONE), 8'(i));
            end
            begin
                repeat (5) @(posedge sysclk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge sysclk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("backpressure");
        chk("bp_stat_rays", 64'(stat_rays), 64'd8);
        chk("bp_stat_hits", 64'(stat_hits), 64'd3);

        // Reset with three requests in flight and the output stalled
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(v3(0, 0, 0), v3(ONE, ONE, ONE), v3(ONE, ONE, ONE), v3(2*ONE, 2*ONE, 2*ONE),
                 rg(0, 100*ONE), 8'(8'hA0 + i));
        @(posedge sysclk);
        #2;
        chk("pre_reset_out_valid", {63'd0, out_valid}, 64'd1);
        rst = 1'b1;
        sb.delete();
        exp_hits = 0;
        #1;
        chk("async_reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("async_reset_stat_rays", 64'(stat_rays),     64'd0);
        chk("async_reset_stat_hits", 64'(stat_hits),     64'd0);
        repeat (2) @(posedge sysclk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge sysclk);
        #1;
        chk("post_reset_no_output", {63'd0, out_valid}, 64'd0);
        chk("post_reset_stat_rays", 64'(stat_rays),     64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/ray_bbox_intersect_pipe.md
# ray_bbox_intersect_pipe

Pipelined, parametrised ray/AABB slab-test unit for the BVH traversal datapath. It accepts one ray/box/range triple per cycle on a valid/ready handshake and produces a hit flag plus clipped `[tmin, tmax]` range four cycles later. The traversal engine uses the carried tag to re-associate each result with its node. Arithmetic is signed fixed point of configurable width, with correct per-axis swap and saturation. The block also keeps running ray and hit statistics.

## Interface
- `W`, 24: signed fixed-point word width.
- `FRAC`, 12: fractional bits (1.0 = `1 << FRAC`).
- `TAG_W`, 8: width of the opaque tag carried alongside each request.
- `CNT_W`, 32: statistics counter width.
- `sysclk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  request present.
- `in_ready`  out  1  request accepted when `in_valid & in_ready`.
- `in_ray_orig`  in  3*W  origin; x = [W-1:0], y = [2W-1:W], z = [3W-1:2W].
- `in_inv_dir`  in  3*W  reciprocal direction, same packing.
- `in_box_min`, `in_box_max`  in  3*W each  box corners, same packing.
- `in_range`  in  2*W  prior range; tmin = [W-1:0], tmax = [2W-1:W].
- `in_tag`  in  TAG_W  passed through unchanged.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  downstream accepts the result.
- `out_hit`  out  1  slab test passed.
- `out_range`  out  2*W  clipped range, same packing as `in_range`.
- `out_tag`  out  TAG_W  tag of the request.
- `stat_clear`  in  1  synchronous clear of both counters.
- `stat_rays`, `stat_hits`  out  CNT_W each  results delivered, and hits among them.

## Operation
- Stage S1 computes `d = box - orig` per axis and corner. It is computed in W+1 bits and saturated to the signed W-bit range.
- Stage S2 computes `t = (d * inv_dir) >>> FRAC`. The full 2W-bit signed product is arithmetic-shifted, then saturated to W bits (max `2^(W-1)-1`, min `-2^(W-1)`).
- Stage S3 handles swap and clip per axis.
  - If that axis's `inv_dir` sign bit is set, swap t0/t1. Each axis uses only its own sign bit.
  - Then `tmin_a = max(t0, range.tmin)` and `tmax_a = min(t1, range.tmax)`.
  - All comparisons are signed.
- Stage S4 reduces and registers.
  - `out_range.tmin = max(tmin_x, tmin_y, tmin_z)`.
  - `out_range.tmax = min(tmax_x, tmax_y, tmax_z)`.
  - `out_hit = out_range.tmax > out_range.tmin`, strict; equality is a miss.
- The tag travels with its data through every stage. Results emerge strictly in acceptance order.
- `inv_dir = 0` on an axis needs no special case: saturated products are treated as ordinary values.
- Statistics update on each output transfer (`out_valid & out_ready`):
  - `stat_rays` increments on every transfer.
  - `stat_hits` increments only when `out_hit` is set.
  - Both counters saturate at all-ones.
  - `stat_clear` zeroes both, taking priority over a same-cycle increment.

## Timing
- Each stage has a `valid` bit. Advance enable is `en = ~out_valid | out_ready`.
- All stages shift together when `en` is high and hold when it is low.
- `in_ready = en`, combinational from `out_valid`/`out_ready` only.
- Latency is exactly 4 cycles from an accepted input to `out_valid` when there is no stall.
- Throughput is one result per cycle under continuous `out_ready`.
- Stall: while `out_valid & ~out_ready`, all outputs hold stable and no input is accepted. No data is lost or duplicated.
- Bubbles (`in_valid` low) propagate as `valid = 0` stages and never generate an output.
- Reset values:
  - `out_valid`, `out_hit`, `out_range`, `out_tag`, `stat_rays`, `stat_hits` and all stage valids are 0.
  - `in_ready` reads 1 one cycle after reset deassertion.
- Reset mid-stream discards all in-flight requests immediately and asynchronously.
- Datapath registers need no reset; valid bits and counters do.

## Structure
- Shared package `data_structs` gains:
  - constant `RT_FRAC_DEFAULT` = 12;
  - functions `sat_w` (saturate a wider signed value to W) and `fx_mul` (multiply, shift, saturate).
  - Existing 24-bit `vec3`/`vec2`/`bbox` stay unchanged; this block uses flattened parametrised ports.
- One sub-module, `rbi_axis_slab`, holds the S1–S3 logic for a single axis, instantiated three times. Its pipeline registers are enabled by `en`.

## Test plan
All values use W=24, FRAC=12, so 1.0 = 0x001000.
- Basic hit: orig 0; inv_dir (1,1,1); box min (1,1,1), max (2,2,2); range (0, 100) -> at cycle +4, hit=1, range (0x001000, 0x002000), tag echoed.
- Negative direction: inv_dir.x = -1.0, box x in [-2,-1], y/z as in basic hit -> x swap gives [1,2]; hit=1, range (1.0, 2.0).
- Miss and tie: box min (3,0,0), max (4,1,1) -> hit=0. A box giving tmax == tmin exactly -> hit=0.
- Saturation: orig.x = -0x7FF000, box.max.x = 0x7FF000, inv_dir.x = 4.0 -> t1x clamps to 0x7FFFFF with no wrap.
- Backpressure: 8 back-to-back requests with tags 0..7, `out_ready` low for cycles 5–8 -> all 8 delivered in tag order. Outputs stay stable during the stall; `stat_rays` = 8.
- Reset mid-stream: assert `rst` with 3 requests in flight -> `out_valid` drops at once, no stale result appears after release, counters = 0.
